trp_sched: RTL and testbench

Job scheduler that sequences the transpose/repack engine. Accepts transpose job descriptors from the command front-end into a small queue, drives the engine's per-job configuration and `init_pulse`, and holds that configuration stable for the whole job. Detects job completion by counting engine write beats, then reports per-job done/error status and an interrupt. Sits between the NPU command decoder and the transpose engine; the multi-dimensional size/stride arrays remain static register inputs and are not part of the scheduler.

---
 rtl/trp_sched_pkg.sv | 49 ++++
 rtl/trp_sched_desc_fifo.sv | 58 +++++
 rtl/trp_sched.sv | 193 +++++++++++++++++++
 tb/tb_trp_sched.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trp_sched_pkg.sv
// Shared types for the transpose job scheduler and engine.
// The HALT state exists only when TRP_SCHED_TIMEOUT_EN is defined.
package trp_sched_pkg;

    localparam int unsigned TRP_AW    = 16;
    localparam int unsigned TRP_BW    = 24;
    localparam int unsigned DRAIN_CYC = 4;

    typedef enum logic [1:0] {
        BIT8_MODE  = 2'b01,
        BIT32_MODE = 2'b10
    } mode_t;

    typedef struct packed {
        logic [3:0]        tag;
        logic [1:0]        mode;
        logic              repack_en;
        logic [TRP_AW-1:0] raddr_base;
        logic [TRP_AW-1:0] waddr_base;
        logic [TRP_AW-1:0] trp_iter_num;
        logic [TRP_AW-1:0] packed_dim_rsize;
        logic [TRP_AW-1:0] packed_dim_rstride;
        logic [TRP_AW-1:0] unpacked_dim_wsize;
        logic [TRP_AW-1:0] unpacked_dim_wstride;
        logic [TRP_BW-1:0] exp_wbeats;
    } trp_desc_t;

`ifdef TRP_SCHED_TIMEOUT_EN
    typedef enum logic [6:0] {
        S_IDLE  = 7'b0000001,
        S_LOAD  = 7'b0000010,
        S_INIT  = 7'b0000100,
        S_RUN   = 7'b0001000,
        S_DRAIN = 7'b0010000,
        S_DONE  = 7'b0100000,
        S_HALT  = 7'b1000000
    } sched_state_t;
`else
    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_LOAD  = 6'b000010,
        S_INIT  = 6'b000100,
        S_RUN   = 6'b001000,
        S_DRAIN = 6'b010000,
        S_DONE  = 6'b100000
    } sched_state_t;
`endif

endpackage

// File: rtl/trp_sched_desc_fifo.sv
// Descriptor queue: depth-QD synchronous FIFO of trp_desc_t with a registered
// not-full flag so desc_rdy comes straight from a flop.
module trp_desc_fifo
    import trp_sched_pkg::*;
#(
    parameter  int unsigned QD = 4,
    localparam int unsigned PW = $clog2(QD)
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      pop,
    input  trp_desc_t wdata,
    output trp_desc_t rdata,
    output logic [PW:0] count,
    output logic      not_full
);

    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          rdy_q, rdy_d;
    logic          push_ok, pop_ok;
    trp_desc_t     mem_q [QD];

    always_comb begin
        push_ok = push & rdy_q;
        pop_ok  = pop & (cnt_q != '0);
        wptr_d  = wptr_q + PW'(push_ok);
        rptr_d  = rptr_q + PW'(pop_ok);
        cnt_d   = cnt_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
        rdy_d   = (cnt_d != (PW+1)'(QD));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            rdy_q  <= 1'b1;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            rdy_q  <= rdy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    assign rdata    = mem_q[rptr_q];
    assign count    = cnt_q;
    assign not_full = rdy_q;

endmodule

// File: rtl/trp_sched.sv
// Transpose engine job scheduler: queues descriptors, shadows the engine config,
// counts write beats to detect completion. Optional watchdog: TRP_SCHED_TIMEOUT_EN.
module trp_sched
    import trp_sched_pkg::*;
#(
    parameter int unsigned AW = TRP_AW,
    parameter int unsigned QD = 4,
    parameter int unsigned BW = TRP_BW
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 desc_vld,
    output logic                 desc_rdy,
    input  trp_desc_t            desc,
    output logic                 trp_init_pulse,
    output logic [1:0]           trp_mode,
    output logic                 trp_repack_en,
    output logic [AW-1:0]        trp_raddr_base,
    output logic [AW-1:0]        trp_waddr_base,
    output logic [AW-1:0]        trp_iter_num,
    output logic [AW-1:0]        trp_packed_dim_rsize,
    output logic [AW-1:0]        trp_packed_dim_rstride,
    output logic [AW-1:0]        trp_unpacked_dim_wsize,
    output logic [AW-1:0]        trp_unpacked_dim_wstride,
    input  logic                 trp_wdata_vld,
    output logic                 busy,
    output logic [$clog2(QD):0]  q_cnt,
    output logic                 job_done,
    output logic [3:0]           job_tag,
    output logic                 job_err,
    output logic [15:0]          done_cnt,
`ifdef TRP_SCHED_TIMEOUT_EN
    input  logic [15:0]          timeout_cyc,
    input  logic                 err_clr,
    output logic                 halted,
`endif
    input  logic                 irq_en,
    input  logic                 irq_clr,
    output logic                 irq
);

    localparam int unsigned DW = $clog2(DRAIN_CYC);

    sched_state_t  state_q, state_d;
    trp_desc_t     shd_q, shd_d, head;
    logic [BW-1:0] beat_q, beat_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          err_q, err_d;
    logic [15:0]   done_cnt_q, done_cnt_d;
    logic          irq_q, irq_d;
    logic          pop, done, done_err;
`ifdef TRP_SCHED_TIMEOUT_EN
    logic [15:0]   wd_q, wd_d;
    logic          wd_fire;
`endif

    trp_desc_fifo #(.QD(QD)) u_fifo (
        .clk      (clk),
        .rst_n    (reset_n),
        .push     (desc_vld),
        .pop      (pop),
        .wdata    (desc),
        .rdata    (head),
        .count    (q_cnt),
        .not_full (desc_rdy)
    );

`ifdef TRP_SCHED_TIMEOUT_EN
    // Watchdog counts consecutive beat-free RUN cycles; fires on the timeout_cyc-th one.
    always_comb begin
        wd_d    = wd_q;
        wd_fire = 1'b0;
        if (state_q == S_INIT) begin
            wd_d = '0;
        end else if (state_q == S_RUN) begin
            wd_d    = trp_wdata_vld ? '0 : wd_q + 16'd1;
            wd_fire = !trp_wdata_vld && (timeout_cyc != '0) && (wd_q == timeout_cyc - 16'd1);
        end
    end
`endif

    always_comb begin
        state_d        = state_q;
        shd_d          = shd_q;
        beat_d         = beat_q;
        drain_d        = drain_q;
        err_d          = err_q;
        pop            = 1'b0;
        trp_init_pulse = 1'b0;
        done           = 1'b0;
        done_err       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (q_cnt != '0) state_d = S_LOAD;
            end
            S_LOAD: begin
                pop     = 1'b1;
                shd_d   = head;
                err_d   = 1'b0;
                state_d = S_INIT;
            end
            S_INIT: begin
                trp_init_pulse = 1'b1;
                beat_d         = '0;
                if (shd_q.exp_wbeats == '0) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (trp_wdata_vld) begin
                    beat_d = beat_q + BW'(1);
                    if (beat_q == BW'(shd_q.exp_wbeats - 1'b1)) begin
                        drain_d = '0;
                        state_d = S_DRAIN;
                    end
`ifdef TRP_SCHED_TIMEOUT_EN
                end else if (wd_fire) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                    state_d  = S_HALT;
`endif
                end
            end
            S_DRAIN: begin
                if (trp_wdata_vld) err_d = 1'b1;
                if (drain_q == DW'(DRAIN_CYC - 1)) state_d = S_DONE;
                else drain_d = drain_q + DW'(1);
            end
            S_DONE: begin
                done     = 1'b1;
                done_err = err_q;
                state_d  = (q_cnt != '0) ? S_LOAD : S_IDLE;
            end
`ifdef TRP_SCHED_TIMEOUT_EN
            S_HALT: begin
                if (err_clr) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
        done_cnt_d = done_cnt_q + 16'(done);
        irq_d      = (done & irq_en) | (irq_q & ~irq_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            shd_q      <= '0;
            beat_q     <= '0;
            drain_q    <= '0;
            err_q      <= 1'b0;
            done_cnt_q <= '0;
            irq_q      <= 1'b0;
`ifdef TRP_SCHED_TIMEOUT_EN
            wd_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            shd_q      <= shd_d;
            beat_q     <= beat_d;
            drain_q    <= drain_d;
            err_q      <= err_d;
            done_cnt_q <= done_cnt_d;
            irq_q      <= irq_d;
`ifdef TRP_SCHED_TIMEOUT_EN
            wd_q       <= wd_d;
`endif
        end
    end

    assign trp_mode                 = shd_q.mode;
    assign trp_repack_en            = shd_q.repack_en;
    assign trp_raddr_base           = shd_q.raddr_base;
    assign trp_waddr_base           = shd_q.waddr_base;
    assign trp_iter_num             = shd_q.trp_iter_num;
    assign trp_packed_dim_rsize     = shd_q.packed_dim_rsize;
    assign trp_packed_dim_rstride   = shd_q.packed_dim_rstride;
    assign trp_unpacked_dim_wsize   = shd_q.unpacked_dim_wsize;
    assign trp_unpacked_dim_wstride = shd_q.unpacked_dim_wstride;
    assign busy                     = (state_q != S_IDLE);
    assign job_done                 = done;
    assign job_tag                  = done ? shd_q.tag : '0;
    assign job_err                  = done_err;
    assign done_cnt                 = done_cnt_q;
    assign irq                      = irq_q;
`ifdef TRP_SCHED_TIMEOUT_EN
    assign halted                   = (state_q == S_HALT);
`endif

endmodule

// File: tb/tb_trp_sched.sv
// Bench for trp_sched: directed scenarios plus randomized jobs checked against a
// descriptor-queue reference model. Watchdog steps run when TRP_SCHED_TIMEOUT_EN is set.
module tb_trp_sched;
    import trp_sched_pkg::*;

    localparam int unsigned AW = 16;
    localparam int unsigned QD = 4;
    localparam int unsigned BW = 24;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            desc_vld;
    logic            desc_rdy;
    trp_desc_t       desc;
    logic            trp_init_pulse;
    logic [1:0]      trp_mode;
    logic            trp_repack_en;
    logic [AW-1:0]   trp_raddr_base, trp_waddr_base, trp_iter_num;
    logic [AW-1:0]   trp_packed_dim_rsize, trp_packed_dim_rstride;
    logic [AW-1:0]   trp_unpacked_dim_wsize, trp_unpacked_dim_wstride;
    logic            trp_wdata_vld;
    logic            busy;
    logic [2:0]      q_cnt;
    logic            job_done;
    logic [3:0]      job_tag;
    logic            job_err;
    logic [15:0]     done_cnt;
    logic            irq_en, irq_clr, irq;
`ifdef TRP_SCHED_TIMEOUT_EN
    logic [15:0]     timeout_cyc;
    logic            err_clr;
    logic            halted;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    trp_desc_t   mq[$];
    logic [15:0] done_exp;

    always #5 clk = ~clk;

    trp_sched #(.AW(AW), .QD(QD), .BW(BW)) dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .desc_vld                 (desc_vld),
        .desc_rdy                 (desc_rdy),
        .desc                     (desc),
        .trp_init_pulse           (trp_init_pulse),
        .trp_mode                 (trp_mode),
        .trp_repack_en            (trp_repack_en),
        .trp_raddr_base           (trp_raddr_base),
        .trp_waddr_base           (trp_waddr_base),
        .trp_iter_num             (trp_iter_num),
        .trp_packed_dim_rsize     (trp_packed_dim_rsize),
        .trp_packed_dim_rstride   (trp_packed_dim_rstride),
        .trp_unpacked_dim_wsize   (trp_unpacked_dim_wsize),
        .trp_unpacked_dim_wstride (trp_unpacked_dim_wstride),
        .trp_wdata_vld            (trp_wdata_vld),
        .busy                     (busy),
        .q_cnt                    (q_cnt),
        .job_done                 (job_done),
        .job_tag                  (job_tag),
        .job_err                  (job_err),
        .done_cnt                 (done_cnt),
`ifdef TRP_SCHED_TIMEOUT_EN
        .timeout_cyc              (timeout_cyc),
        .err_clr                  (err_clr),
        .halted                   (halted),
`endif
        .irq_en                   (irq_en),
        .irq_clr                  (irq_clr),
        .irq                      (irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic chk_cfg(input string name, input trp_desc_t d);
        chk({name, "_lo"},
            {13'd0, trp_mode, trp_repack_en, trp_raddr_base, trp_waddr_base, trp_iter_num},
            {13'd0, d.mode, d.repack_en, d.raddr_base, d.waddr_base, d.trp_iter_num});
        chk({name, "_hi"},
            {trp_packed_dim_rsize, trp_packed_dim_rstride, trp_unpacked_dim_wsize, trp_unpacked_dim_wstride},
            {d.packed_dim_rsize, d.packed_dim_rstride, d.unpacked_dim_wsize, d.unpacked_dim_wstride});
    endtask

    task automatic rand_desc(input logic [3:0] tag, input logic [BW-1:0] beats, output trp_desc_t d);
        d.tag                  = tag;
        d.mode                 = ($urandom_range(0, 1) == 0) ? BIT8_MODE : BIT32_MODE;
        d.repack_en            = 1'($urandom);
        d.raddr_base           = 16'($urandom);
        d.waddr_base           = 16'($urandom);
        d.trp_iter_num         = 16'($urandom);
        d.packed_dim_rsize     = 16'($urandom);
        d.packed_dim_rstride   = 16'($urandom);
        d.unpacked_dim_wsize   = 16'($urandom);
        d.unpacked_dim_wstride = 16'($urandom);
        d.exp_wbeats           = beats;
    endtask

    // Model: a push is kept only while fewer than QD jobs wait.
    task automatic push(input trp_desc_t d);
        desc     = d;
        desc_vld = 1'b1;
        if (mq.size() < QD) mq.push_back(d);
        tick();
        desc_vld = 1'b0;
        desc     = '0;
    endtask

    task automatic wait_start(output trp_desc_t cur, output int lat);
        lat = 0;
        while (!trp_init_pulse && lat < 40) begin
            tick();
            lat++;
        end
        chk("init_seen", trp_init_pulse, 1);
        cur = (mq.size() != 0) ? mq.pop_front() : '0;
        chk_cfg("cfg_at_init", cur);
    endtask

    // Starts in the INIT cycle; drives the job's beats and checks its completion.
    task automatic finish(input trp_desc_t cur, input bit extra, input bit clr, input bit noise);
        int lat;
        bit exp_err;
        exp_err = (cur.exp_wbeats == '0) || extra;
        trp_wdata_vld = noise;
        tick();
        trp_wdata_vld = 1'b0;
        chk("init_one_cycle", trp_init_pulse, 0);
        if (cur.exp_wbeats == '0) begin
            chk("zero_done_next", job_done, 1);
        end else begin
            chk("busy_run", busy, 1);
            for (int b = 0; b < int'(cur.exp_wbeats); b++) begin
                repeat ($urandom_range(0, 2)) tick();
                trp_wdata_vld = 1'b1;
                tick();
                trp_wdata_vld = 1'b0;
            end
            lat = 0;
            if (extra) begin
                trp_wdata_vld = 1'b1;
                tick();
                trp_wdata_vld = 1'b0;
                lat = 1;
            end
            while (!job_done && lat < 20) begin
                tick();
                lat++;
            end
            chk("done_latency", lat, DRAIN_CYC);
        end
        chk("job_tag", job_tag, cur.tag);
        chk("job_err", job_err, exp_err);
        chk_cfg("cfg_hold", cur);
        irq_clr = clr;
        tick();
        irq_clr = 1'b0;
        done_exp++;
        chk("done_cnt", done_cnt, done_exp);
        chk("done_pulse_width", job_done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        trp_desc_t d, cur;
        trp_desc_t jobs[4];
        int lat, seen;

        reset_n = 1'b0; desc_vld = 1'b0; desc = '0; trp_wdata_vld = 1'b0;
        irq_en = 1'b0; irq_clr = 1'b0; done_exp = '0;
`ifdef TRP_SCHED_TIMEOUT_EN
        timeout_cyc = '0; err_clr = 1'b0;
`endif
        repeat (3) tick();
        chk("rst_desc_rdy", desc_rdy, 1);
        chk("rst_q_cnt", q_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_outs", {trp_init_pulse, job_done, job_tag, job_err, irq}, 0);
        chk("rst_done_cnt", done_cnt, 0);
        chk_cfg("rst_cfg", '0);
        reset_n = 1'b1;
        tick();

        // Single job: tag 3, 8-bit mode, 8 beats
        rand_desc(4'd3, 24'd8, d);
        d.mode = BIT8_MODE;
        push(d);
        wait_start(cur, lat);
        chk("push_to_init", lat, 2);
        finish(cur, 1'b0, 1'b0, 1'b0);
        chk("irq_off", irq, 0);

        // Queue fill while a job runs, overflow push dropped, tags in order
        rand_desc(4'hA, 24'd5, d);
        push(d);
        wait_start(cur, lat);
        for (int i = 0; i < 4; i++) begin
            rand_desc(4'(i + 4), 24'($urandom_range(1, 6)), jobs[i]);
            push(jobs[i]);
        end
        chk("full_q_cnt", q_cnt, 4);
        chk("full_rdy", desc_rdy, 0);
        rand_desc(4'hF, 24'd3, d);
        push(d);
        chk("overflow_dropped", q_cnt, 4);
        finish(cur, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            wait_start(cur, lat);
            chk("b2b_gap", lat, 1);
            chk("rdy_after_load", desc_rdy, 1);
            finish(cur, 1'b0, 1'b0, 1'b0);
        end

        // Zero expected beats
        rand_desc(4'd9, 24'd0, d);
        push(d);
        wait_start(cur, lat);
        finish(cur, 1'b0, 1'b0, 1'b1);

        // Extra beat in DRAIN, then a normal job
        rand_desc(4'd1, 24'd8, d);
        push(d);
        rand_desc(4'd2, 24'd8, d);
        push(d);
        wait_start(cur, lat);
        finish(cur, 1'b1, 1'b0, 1'b0);
        wait_start(cur, lat);
        finish(cur, 1'b0, 1'b0, 1'b0);

        // irq: set wins over a simultaneous clear; later clear drops it
        irq_en = 1'b1;
        rand_desc(4'd6, 24'd2, d);
        push(d);
        wait_start(cur, lat);
        finish(cur, 1'b0, 1'b1, 1'b0);
        chk("irq_set_wins", irq, 1);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        chk("irq_cleared", irq, 0);
        irq_en = 1'b0;

        // Randomized batches
        for (int j = 0; j < 12; j++) begin
            int n;
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) begin
                rand_desc(4'($urandom), 24'($urandom_range(0, 10)), d);
                push(d);
            end
            for (int k = 0; k < n; k++) begin
                wait_start(cur, lat);
                finish(cur, ($urandom_range(0, 3) == 0) && (cur.exp_wbeats != '0),
                       1'b0, 1'($urandom));
            end
        end

        // Reset mid-RUN aborts the job without a completion
        rand_desc(4'd7, 24'd8, d);
        push(d);
        wait_start(cur, lat);
        tick();
        trp_wdata_vld = 1'b1;
        tick();
        tick();
        trp_wdata_vld = 1'b0;
        reset_n = 1'b0;
        #2;
        chk("midrst_busy", busy, 0);
        chk("midrst_done_cnt", done_cnt, 0);
        chk("midrst_q", {desc_rdy, q_cnt}, 4'b1000);
        chk_cfg("midrst_cfg", '0);
        tick();
        reset_n = 1'b1;
        mq.delete();
        done_exp = '0;
        seen = 0;
        repeat (12) begin
            tick();
            if (job_done) seen++;
        end
        chk("midrst_no_done", seen, 0);
        chk("midrst_idle", busy, 0);

`ifdef TRP_SCHED_TIMEOUT_EN
        // Watchdog: stall after 2 of 8 beats
        timeout_cyc = 16'd20;
        rand_desc(4'd5, 24'd8, d);
        push(d);
        wait_start(cur, lat);
        tick();
        trp_wdata_vld = 1'b1;
        tick();
        tick();
        trp_wdata_vld = 1'b0;
        lat = 0;
        while (!job_done && lat < 40) begin
            tick();
            lat++;
        end
        chk("wd_latency", lat, 19);
        chk("wd_err", job_err, 1);
        chk("wd_tag", job_tag, 5);
        rand_desc(4'd8, 24'd3, d);
        push(d);
        done_exp++;
        chk("wd_halted", halted, 1);
        chk("wd_done_cnt", done_cnt, done_exp);
        repeat (3) tick();
        chk("halt_q_held", q_cnt, 1);
        chk("halt_stays", halted, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("halt_cleared", halted, 0);
        timeout_cyc = '0;
        wait_start(cur, lat);
        finish(cur, 1'b0, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
